// File: rtl/display_scan.sv
// rtl/display_scan.sv - time-multiplexed seven-segment digit scanner with tear-free updates
module display_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [3:0]            digit_out,
  output logic [DIGITS-1:0]     an,
  output logic                  blank,
  output logic                  frame
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic                pend_v_q, pend_v_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [3:0]          digit_out_q, digit_out_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                blank_q, blank_d;
  logic                frame_q, frame_d;

  logic                tick;
  logic                xfer;
  logic [IDX_W-1:0]    idx_nxt;
  logic [DIGITS-1:0]   lz_mask;
  logic                all_zero;
  logic [3:0]          nib;
  logic                lz_sel;
  logic [DIGITS-1:0]   an_sel;
  logic                blanked;

  // Prescaler, slot index and the pending/display double buffer.
  always_comb begin
    tick     = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    idx_nxt  = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    idx_d    = tick ? idx_nxt : idx_q;
    xfer     = tick && (idx_nxt == '0);

    // Transfer reads the old pend; a same-cycle load refills it and keeps it valid.
    disp_d   = disp_q;
    pend_v_d = pend_v_q;
    if (xfer && pend_v_q) begin
      disp_d   = pend_q;
      pend_v_d = 1'b0;
    end
    pend_d = pend_q;
    if (load) begin
      pend_d   = value;
      pend_v_d = 1'b1;
    end
  end

  // Leading-zero mask and selection of the next slot, based on post-transfer disp.
  always_comb begin
    all_zero = 1'b1;
    lz_mask  = '0;
    for (int j = DIGITS - 1; j >= 0; j--) begin
      all_zero   = all_zero & (disp_d[4*j +: 4] == 4'h0);
      lz_mask[j] = all_zero;
    end
    nib    = 4'h0;
    lz_sel = 1'b0;
    an_sel = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        nib       = disp_d[4*i +: 4];
        lz_sel    = lz_mask[i];
        an_sel[i] = 1'b0;
      end
    end
    blanked = blank_lz && (idx_nxt != '0) && lz_sel;
  end

  // Outputs only move on a tick; frame is a single-cycle pulse.
  always_comb begin
    digit_out_d = digit_out_q;
    an_d        = an_q;
    blank_d     = blank_q;
    frame_d     = 1'b0;
    if (tick) begin
      digit_out_d = blanked ? 4'h0 : nib;
      an_d        = blanked ? '1 : an_sel;
      blank_d     = blanked;
      frame_d     = xfer;
    end
  end

  // State registers; reset discards both displayed and pending data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= IDX_W'(DIGITS - 1);
      pend_q      <= '0;
      pend_v_q    <= 1'b0;
      disp_q      <= '0;
      digit_out_q <= 4'h0;
      an_q        <= '1;
      blank_q     <= 1'b1;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_v_q    <= pend_v_d;
      disp_q      <= disp_d;
      digit_out_q <= digit_out_d;
      an_q        <= an_d;
      blank_q     <= blank_d;
      frame_q     <= frame_d;
    end
  end

  assign digit_out = digit_out_q;
  assign an        = an_q;
  assign blank     = blank_q;
  assign frame     = frame_q;

endmodule

// File: tb/tb_display_scan.sv
// tb/tb_display_scan.sv - directed self-checking bench for display_scan
module tb_display_scan;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  digit_out;
  logic [3:0]  an;
  logic        blank;
  logic        frame;

  int errors = 0;
  int checks = 0;

  display_scan #(.DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .blank_lz(blank_lz),
    .digit_out(digit_out), .an(an), .blank(blank), .frame(frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame && n < 100);
    check("frame_found", frame, 1);
  endtask

  // Starts on the first cycle of a frame and ends on its last cycle.
  task automatic check_frame(input string tag, input logic [15:0] v, input logic [3:0] bm);
    int s;
    logic [3:0] e_an;
    logic [3:0] e_d;
    for (int c = 0; c < 16; c++) begin
      if (c != 0) @(negedge clk);
      s    = c / 4;
      e_an = bm[s] ? 4'hF : ~(4'b0001 << s);
      e_d  = bm[s] ? 4'h0 : v[4*s +: 4];
      check($sformatf("%s_an_c%0d", tag, c), an, e_an);
      check($sformatf("%s_dig_c%0d", tag, c), digit_out, e_d);
      check($sformatf("%s_blk_c%0d", tag, c), blank, bm[s]);
      check($sformatf("%s_frm_c%0d", tag, c), frame, (c == 0));
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; value = '0; load = 1'b0; blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_an", an, 4'hF);
    check("rst_blank", blank, 1);
    check("rst_dig", digit_out, 0);
    check("rst_frame", frame, 0);
    rst = 1'b0;

    // First tick lands on the 4th edge after release.
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("pre_tick_an%0d", k), an, 4'hF);
      check($sformatf("pre_tick_blank%0d", k), blank, 1);
      check($sformatf("pre_tick_frame%0d", k), frame, 0);
    end
    @(negedge clk);
    check("first_an", an, 4'hE);
    check("first_dig", digit_out, 0);
    check("first_blank", blank, 0);
    check("first_frame", frame, 1);
    @(negedge clk);
    check("first_frame_drop", frame, 0);

    // Scan order over two frames.
    pulse_load(16'h1A2F);
    wait_frame();
    check_frame("scan1", 16'h1A2F, 4'b0000);
    wait_frame();
    check_frame("scan2", 16'h1A2F, 4'b0000);

    // Tear-free: load during slot 2, rest of frame keeps old value.
    wait_frame();
    repeat (8) @(negedge clk);
    value = 16'h1234;
    load  = 1'b1;
    check("tear_an_c8", an, 4'b1011);
    check("tear_dig_c8", digit_out, 4'hA);
    for (int c = 9; c < 16; c++) begin
      @(negedge clk);
      load = 1'b0;
      check($sformatf("tear_an_c%0d", c), an, (c < 12) ? 4'b1011 : 4'b0111);
      check($sformatf("tear_dig_c%0d", c), digit_out, (c < 12) ? 4'hA : 4'h1);
    end
    wait_frame();
    check_frame("tear_new", 16'h1234, 4'b0000);

    // Load coincident with the frame-transfer tick.
    wait_frame();
    pulse_load(16'h1111);
    repeat (14) @(negedge clk);
    value = 16'h2222;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check_frame("coinc1", 16'h1111, 4'b0000);
    wait_frame();
    check_frame("coinc2", 16'h2222, 4'b0000);

    // Leading-zero blanking.
    wait_frame();
    blank_lz = 1'b1;
    pulse_load(16'h0050);
    wait_frame();
    check_frame("lz50", 16'h0050, 4'b1100);
    wait_frame();
    pulse_load(16'h9999);
    @(negedge clk);
    pulse_load(16'h0000);
    wait_frame();
    check_frame("lz00", 16'h0000, 4'b1110);

    // Asynchronous reset mid-frame with a pending value outstanding.
    blank_lz = 1'b0;
    wait_frame();
    pulse_load(16'hBEEF);
    wait_frame();
    repeat (8) @(negedge clk);
    check("pre_rst_an", an, 4'b1011);
    check("pre_rst_dig", digit_out, 4'hE);
    pulse_load(16'hC0DE);
    #2 rst = 1'b1;
    #1;
    check("async_an", an, 4'hF);
    check("async_blank", blank, 1);
    check("async_dig", digit_out, 0);
    check("async_frame", frame, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_frame();
    check_frame("post_rst0", 16'h0000, 4'b0000);
    wait_frame();
    check_frame("post_rst1", 16'h0000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexing scanner for a multi-digit seven-segment display. It sits directly upstream of the 4-bit hex-to-seven-segment decoder. It holds a multi-digit hex value, selects one digit per refresh slot, and presents that digit's nibble to the decoder together with the matching active-low anode enable. Value updates are applied only at frame boundaries, so a frame never shows a mix of old and new digits. Optional leading-zero blanking is provided.

## Interface
- DIGITS, 4: number of display digits (2..8). Digit 0 is least significant.
- REFRESH_DIV, 50000: clock cycles per digit slot (≥2).
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- value  input  4*DIGITS  new display value; digit i occupies bits [4i+3:4i].
- load  input  1  one-cycle strobe that captures value into the pending register.
- blank_lz  input  1  enables leading-zero blanking; sampled at each tick.
- digit_out  output  4  nibble of the active digit; drives the decoder input.
- an  output  DIGITS  active-low anode enables; at most one bit is low at any time.
- blank  output  1  high when the current slot is blanked; downstream forces segments off.
- frame  output  1  one-cycle pulse on the cycle digit 0 becomes active.

## Operation
- Prescaler `cnt` counts 0..REFRESH_DIV-1 and then wraps to 0. `tick` is asserted when cnt==REFRESH_DIV-1.
- Digit index `idx` advances on each tick. It wraps from DIGITS-1 to 0.
- Registers:
  - `pend` (4*DIGITS) and `pend_v` form the pending buffer.
  - `disp` (4*DIGITS) holds the value currently being shown.
- When load=1: pend<=value and pend_v<=1.
- Frame transfer happens on a tick where the next idx==0. If pend_v=1, then disp<=pend and pend_v<=0.
- When load and the frame-transfer tick occur in the same cycle:
  - The transfer uses the old pend contents.
  - pend takes the new value, and pend_v stays 1.
  - The new value is applied at the following frame.
- Leading-zero blanking: slot i is blanked when blank_lz=1, i≠0, and disp digits DIGITS-1 down to i are all 4'h0. Digit 0 is never blanked.
- Output update on each tick, all registered and changing together, using the post-transfer disp:
  - digit_out <= disp nibble of the next idx.
  - Unblanked slot: an <= one-hot-low at the next idx, and blank<=0.
  - Blanked slot: an <= all ones, blank<=1, and digit_out<=0.
- frame<=1 on the tick that selects idx 0 and 0 on every other cycle.
- Between ticks, all outputs hold their values.

## Timing
- Reset values:
  - cnt=0 and idx=DIGITS-1, so the first tick selects digit 0.
  - pend=0, pend_v=0, disp=0.
  - digit_out=4'h0, an=all ones, blank=1, frame=0.
- First tick occurs REFRESH_DIV cycles after rst deasserts. Outputs show digit 0 starting on the following cycle.
- Slot length is exactly REFRESH_DIV cycles. Frame period is DIGITS*REFRESH_DIV cycles.
- Load-to-display latency: a load during frame N is displayed in frame N+1, starting at the first cycle of that frame. It is never displayed mid-frame.
- Multiple loads within one frame: the last one wins.
- Asserting rst mid-frame returns every register to its reset value immediately and discards pending data.
- blank_lz changes take effect at the next tick. No glitch occurs between ticks.

## Test plan
- Reset release, DIGITS=4, REFRESH_DIV=4:
  - an=4'b1111 and blank=1 for the first 4 cycles after reset.
  - At cycle 5: an=4'b1110, digit_out=0, blank=0, frame=1 for exactly one cycle.
- Scan order: load 16'h1A2F, then run 2 frames.
  - Second frame sequence: (an,digit_out) = (1110,F), (1101,2), (1011,A), (0111,1).
  - Each slot lasts 4 cycles. frame pulses once per 16 cycles.
- Tear-free update: load 16'h1234 mid-frame (slot 2 active).
  - The remaining slots of the current frame still show the old value.
  - The next frame shows 4,3,2,1.
- Load coincident with frame-transfer tick: pend holds 16'h1111 with pend_v=1, and 16'h2222 is loaded on the transfer tick.
  - The next frame shows 1s.
  - The frame after that shows 2s.
- Leading-zero blanking: blank_lz=1, value 16'h0050.
  - Slots 3 and 2 have an=1111 and blank=1.
  - Slot 1 shows 5, and slot 0 shows 0.
  - With value 16'h0000, only slot 0 is lit, showing 0.
- Reset mid-operation: assert rst during slot 2 after loading 16'hBEEF.
  - Outputs return to reset values within the same cycle (asynchronous).
  - After release, the display shows all zeros: disp cleared, pending value lost.
